// File: rtl/conv_layer_pkg.sv
// rtl/conv_layer_pkg.sv - shared encodings and defaults for the conv-layer input sequencer
package conv_layer_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE    = 2'd0,
      CMD_PRELOAD = 2'd1,
      CMD_SHIFT   = 2'd2,
      CMD_LOAD    = 2'd3
   } cmd_t;

   typedef enum logic [1:0] {
      ACK_IDLE        = 2'd0,
      ACK_PRELOAD_FIN = 2'd1,
      ACK_SHIFT_FIN   = 2'd2,
      ACK_LOAD_FIN    = 2'd3
   } ack_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRELOAD,
      S_SHIFT,
      S_LOAD,
      S_DONE,
      S_ERR
   } state_t;

   localparam int DEF_IMAGE_ROWS  = 8;
   localparam int DEF_KERNEL_SIZE = 3;

endpackage

// File: rtl/conv_layer_ack_timer.sv
// rtl/conv_layer_ack_timer.sv - ack wait counter; expired flags the last allowed waiting cycle
module conv_layer_ack_timer #(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   logic [TO_W-1:0] count;

   // Expired one count early so the transition lands on the TIMEOUT-th edge.
   assign expired = count_en && (count == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (enable) begin
         if (clear) begin
            count <= '0;
         end else if (count_en && !expired) begin
            count <= count + TO_W'(1);
         end
      end
   end

endmodule

// File: rtl/conv_layer_input_ctrl.sv
// rtl/conv_layer_input_ctrl.sv - preload/shift/load sequencer for one conv-layer input feature map
module conv_layer_input_ctrl
   import conv_layer_pkg::*;
#(
   parameter int IMAGE_ROWS  = DEF_IMAGE_ROWS,
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int ROW_W       = 4,
   parameter int TIMEOUT     = 64,
   parameter int TO_W        = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       ack,
   output logic [1:0]       cmd,
   output logic             kernel_en,
   output logic             row_valid,
   output logic [ROW_W-1:0] row_idx,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_ROWS - KERNEL_SIZE);

   state_t           state_q, state_n;
   cmd_t             cmd_q, cmd_n;
   ack_t             ack_c;
   logic             kernel_en_n, row_valid_n, busy_n, done_n, error_n;
   logic [ROW_W-1:0] row_idx_n;
   logic             issue, go_err, expired;

   assign ack_c = ack_t'(ack);
   assign cmd   = cmd_q;

   conv_layer_ack_timer #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .clear    (issue),
      .count_en (cmd_q != CMD_IDLE),
      .expired  (expired)
   );

   // In SHIFT/LOAD, cmd_q==IDLE marks the mandatory gap cycle before the command is issued.
   always_comb begin
      state_n     = state_q;
      cmd_n       = cmd_q;
      row_idx_n   = row_idx;
      busy_n      = busy;
      error_n     = error;
      row_valid_n = 1'b0;
      done_n      = 1'b0;
      issue       = 1'b0;
      go_err      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_n   = S_PRELOAD;
               cmd_n     = CMD_PRELOAD;
               busy_n    = 1'b1;
               error_n   = 1'b0;
               row_idx_n = '0;
               issue     = 1'b1;
            end
         end
         S_PRELOAD: begin
            if (ack_c == ACK_PRELOAD_FIN) begin
               state_n = S_SHIFT;
               cmd_n   = CMD_IDLE;
            end else if (expired) begin
               go_err = 1'b1;
            end
         end
         S_SHIFT: begin
            if (cmd_q == CMD_IDLE) begin
               cmd_n = CMD_SHIFT;
               issue = 1'b1;
            end else if (ack_c == ACK_SHIFT_FIN) begin
               cmd_n       = CMD_IDLE;
               row_valid_n = 1'b1;
               state_n     = (row_idx == LAST_ROW) ? S_DONE : S_LOAD;
            end else if (expired) begin
               go_err = 1'b1;
            end
         end
         S_LOAD: begin
            // row_idx advances here so the row_valid pulse still shows the completed row.
            if (cmd_q == CMD_IDLE) begin
               cmd_n     = CMD_LOAD;
               issue     = 1'b1;
               row_idx_n = row_idx + ROW_W'(1);
            end else if (ack_c == ACK_LOAD_FIN) begin
               state_n = S_SHIFT;
               cmd_n   = CMD_IDLE;
            end else if (expired) begin
               go_err = 1'b1;
            end
         end
         S_DONE: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
         S_ERR: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      if (go_err) begin
         state_n = S_ERR;
         cmd_n   = CMD_IDLE;
         error_n = 1'b1;
         busy_n  = 1'b0;
      end

      if (abort && (state_q != S_IDLE)) begin
         state_n     = S_IDLE;
         cmd_n       = CMD_IDLE;
         busy_n      = 1'b0;
         row_idx_n   = '0;
         row_valid_n = 1'b0;
         done_n      = 1'b0;
      end

      kernel_en_n = (cmd_n == CMD_SHIFT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cmd_q     <= CMD_IDLE;
         kernel_en <= 1'b0;
         row_valid <= 1'b0;
         row_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else if (enable) begin
         state_q   <= state_n;
         cmd_q     <= cmd_n;
         kernel_en <= kernel_en_n;
         row_valid <= row_valid_n;
         row_idx   <= row_idx_n;
         busy      <= busy_n;
         done      <= done_n;
         error     <= error_n;
      end else begin
         row_valid <= 1'b0;
         done      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// tb/tb_conv_layer_input_ctrl.sv - scoreboard bench for conv_layer_input_ctrl
module tb_conv_layer_input_ctrl;
   import conv_layer_pkg::*;

   logic       clk = 1'b0;
   logic       rst, enable, start, abort;
   logic [1:0] ack, cmd;
   logic       kernel_en, row_valid, busy, done, error;
   logic [3:0] row_idx;

   always #5 clk = ~clk;

   conv_layer_input_ctrl #(
      .IMAGE_ROWS  (8),
      .KERNEL_SIZE (3),
      .ROW_W       (4),
      .TIMEOUT     (64),
      .TO_W        (7)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .start     (start),
      .abort     (abort),
      .ack       (ack),
      .cmd       (cmd),
      .kernel_en (kernel_en),
      .row_valid (row_valid),
      .row_idx   (row_idx),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   logic [1:0] exp_cmd_q[$];
   logic [3:0] exp_row_q[$];
   int         exp_done_q[$];
   bit         auto_ack = 1'b0;
   int         ack_delay = 5;
   int         r_cnt = 0;
   logic [1:0] prev_cmd = 2'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0d expected none", name, act);
   endtask

   // Monitor: pops expectations whenever the DUT presents an event.
   always @(negedge clk) begin
      if (rst) begin
         prev_cmd = 2'd0;
      end else begin
         if (cmd != prev_cmd && cmd != 2'd0) begin
            if (prev_cmd != 2'd0) fail("cmd_no_gap", 32'(cmd));
            if (exp_cmd_q.size() == 0) fail("cmd_unexpected", 32'(cmd));
            else check("cmd_seq", 32'(cmd), 32'(exp_cmd_q.pop_front()));
            check("kernel_en", 32'(kernel_en), 32'(cmd == 2'd2));
         end
         if (row_valid) begin
            if (exp_row_q.size() == 0) fail("row_valid_unexpected", 32'(row_idx));
            else check("row_idx", 32'(row_idx), 32'(exp_row_q.pop_front()));
         end
         if (done) begin
            if (exp_done_q.size() == 0) fail("done_unexpected", 32'(done));
            else check("done", 32'(done), 32'(exp_done_q.pop_front()));
         end
         prev_cmd = cmd;
      end
   end

   // Automatic responder: acks the pending command after ack_delay enabled cycles.
   always @(negedge clk) begin
      if (auto_ack) begin
         ack = 2'd0;
         if (cmd == 2'd0) begin
            r_cnt = 0;
         end else if (enable && !rst) begin
            r_cnt++;
            if (r_cnt == ack_delay) begin
               r_cnt = 0;
               case (cmd)
                  2'd1:    ack = 2'd1;
                  2'd2:    ack = 2'd2;
                  default: ack = 2'd3;
               endcase
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic pulse_ack(input logic [1:0] a);
      ack = a;
      tick();
      ack = 2'd0;
   endtask

   task automatic wait_cmd(input logic [1:0] c, input string name);
      int n = 0;
      while (cmd !== c && n < 300) begin
         tick();
         n++;
      end
      if (cmd !== c) fail(name, 32'(cmd));
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_cmd_q.size() + exp_row_q.size() + exp_done_q.size()) != 0 && n < 3000) begin
         tick();
         n++;
      end
      tick(3);
      check(name, 32'(exp_cmd_q.size() + exp_row_q.size() + exp_done_q.size()), 32'd0);
   endtask

   task automatic push_full_map();
      exp_cmd_q.push_back(2'd1);
      exp_cmd_q.push_back(2'd2);
      for (int i = 0; i < 5; i++) begin
         exp_cmd_q.push_back(2'd3);
         exp_cmd_q.push_back(2'd2);
      end
      for (int i = 0; i < 6; i++) exp_row_q.push_back(4'(i));
      exp_done_q.push_back(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; enable = 1'b1; start = 1'b0; abort = 1'b0; ack = 2'd0;
      tick(2);
      check("rst_cmd", 32'(cmd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_row_idx", 32'(row_idx), 32'd0);
      check("rst_kernel_en", 32'(kernel_en), 32'd0);
      rst = 1'b0;
      tick(2);

      // Full map: 12 commands, rows 0..5, one done.
      push_full_map();
      auto_ack = 1'b1;
      pulse_start();
      check("busy_after_start", 32'(busy), 32'd1);
      check("cmd_after_start", 32'(cmd), 32'd1);
      wait_drain("full_map_drain");
      check("full_busy_end", 32'(busy), 32'd0);
      check("full_cmd_end", 32'(cmd), 32'd0);
      auto_ack = 1'b0; ack = 2'd0; r_cnt = 0;
      tick(2);

      // Mismatched ack during SHIFT is ignored.
      exp_cmd_q.push_back(2'd1); exp_cmd_q.push_back(2'd2); exp_cmd_q.push_back(2'd3);
      exp_row_q.push_back(4'd0);
      pulse_start();
      wait_cmd(2'd1, "wait_preload");
      tick(2);
      pulse_ack(2'd1);
      wait_cmd(2'd2, "wait_shift");
      tick(2);
      pulse_ack(2'd3);
      tick(3);
      check("ignored_ack_cmd", 32'(cmd), 32'd2);
      check("ignored_ack_kernel_en", 32'(kernel_en), 32'd1);
      pulse_ack(2'd2);
      wait_cmd(2'd3, "wait_load");
      pulse_abort();
      check("abort_row_idx", 32'(row_idx), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      wait_drain("ignored_drain");

      // Timeout with no ack after PRELOAD.
      exp_cmd_q.push_back(2'd1);
      pulse_start();
      n = 1;
      while (!error && n < 200) begin
         tick();
         n++;
      end
      check("timeout_cycle", 32'(n), 32'd65);
      check("timeout_cmd", 32'(cmd), 32'd0);
      check("timeout_busy", 32'(busy), 32'd0);
      tick();
      check("error_sticky", 32'(error), 32'd1);
      exp_cmd_q.push_back(2'd1);
      pulse_start();
      check("start_clears_error", 32'(error), 32'd0);
      check("restart_cmd", 32'(cmd), 32'd1);
      pulse_abort();
      wait_drain("timeout_drain");

      // Abort on the same cycle as the third SHIFT_FIN.
      exp_cmd_q.push_back(2'd1);
      for (int i = 0; i < 2; i++) begin
         exp_cmd_q.push_back(2'd2);
         exp_cmd_q.push_back(2'd3);
         exp_row_q.push_back(4'(i));
      end
      exp_cmd_q.push_back(2'd2);
      pulse_start();
      wait_cmd(2'd1, "ab_preload");
      tick(2);
      pulse_ack(2'd1);
      for (int i = 0; i < 2; i++) begin
         wait_cmd(2'd2, "ab_shift");
         tick(2);
         pulse_ack(2'd2);
         wait_cmd(2'd3, "ab_load");
         tick(2);
         pulse_ack(2'd3);
      end
      wait_cmd(2'd2, "ab_shift3");
      tick();
      ack = 2'd2; abort = 1'b1;
      tick();
      ack = 2'd0; abort = 1'b0;
      check("ab_cmd", 32'(cmd), 32'd0);
      check("ab_row_valid", 32'(row_valid), 32'd0);
      check("ab_row_idx", 32'(row_idx), 32'd0);
      check("ab_kernel_en", 32'(kernel_en), 32'd0);
      check("ab_busy", 32'(busy), 32'd0);
      wait_drain("abort_drain");

      // enable held low mid-LOAD freezes everything; sequence resumes unchanged.
      push_full_map();
      auto_ack = 1'b1;
      pulse_start();
      wait_cmd(2'd3, "en_wait_load");
      tick(2);
      enable = 1'b0;
      tick(10);
      check("en_hold_cmd", 32'(cmd), 32'd3);
      check("en_hold_row_idx", 32'(row_idx), 32'd1);
      enable = 1'b1;
      wait_drain("enable_drain");
      check("en_error", 32'(error), 32'd0);
      check("en_busy_end", 32'(busy), 32'd0);

      // Asynchronous reset mid-map.
      push_full_map();
      pulse_start();
      n = 0;
      while (row_idx != 4'd2 && n < 300) begin
         tick();
         n++;
      end
      check("reach_row2", 32'(row_idx), 32'd2);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_cmd", 32'(cmd), 32'd0);
      check("arst_kernel_en", 32'(kernel_en), 32'd0);
      check("arst_row_valid", 32'(row_valid), 32'd0);
      check("arst_row_idx", 32'(row_idx), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_error", 32'(error), 32'd0);
      auto_ack = 1'b0; ack = 2'd0; r_cnt = 0;
      exp_cmd_q.delete(); exp_row_q.delete(); exp_done_q.delete();
      tick();
      rst = 1'b0;
      tick(3);
      check("post_rst_cmd", 32'(cmd), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/conv_layer_input_ctrl.md
Name: conv_layer_input_ctrl

Overview:
- Sequencer directly upstream of the conv-layer input interface; drives its 2-bit cmd and consumes its 2-bit ack.
- Walks one input feature map through three phases:
  - preload: KERNEL_SIZE rows into the window.
  - shift: produce one output row.
  - load: bring in one new row, then shift again. Repeats until every output row is done.
- Reports output-row boundaries and progress to the downstream kernel/output stage, and to the layer-level controller.

Parameters:
- IMAGE_ROWS, 8, number of input rows per feature map.
- KERNEL_SIZE, 3, kernel height/width; output rows = IMAGE_ROWS-KERNEL_SIZE+1.
- ROW_W, 4, width of row counters; must satisfy 2^ROW_W > IMAGE_ROWS.
- TIMEOUT, 64, cycles to wait for an expected ack before flagging error.
- TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  global stall; low freezes all state, counters and outputs.
- start  in  1  one-cycle pulse; begins a feature map when idle.
- abort  in  1  one-cycle pulse; cancels the current map.
- ack  in  2  from input interface: 0 IDLE, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN.
- cmd  out  2  to input interface: 0 IDLE, 1 PRELOAD, 2 SHIFT, 3 LOAD.
- kernel_en  out  1  high while cmd==SHIFT; downstream kernel accumulates.
- row_valid  out  1  one-cycle pulse when an output row completes.
- row_idx  out  ROW_W  index of the current/just-completed output row.
- busy  out  1  high from the cycle after an accepted start until DONE/ERR exits.
- done  out  1  one-cycle pulse after the last output row.
- error  out  1  sticky timeout flag; cleared by start or rst.

Behaviour:
- Reset: all outputs are registered. Reset values: cmd=IDLE, kernel_en=0, row_valid=0, row_idx=0, busy=0, done=0, error=0, state=S_IDLE, timeout counter=0. rst asserted mid-map returns everything to reset values immediately, regardless of clk.
- States: S_IDLE, S_PRELOAD, S_SHIFT, S_LOAD, S_DONE, S_ERR.
- S_IDLE:
  - start=1 -> S_PRELOAD; cmd=PRELOAD and busy=1 on the following edge (1-cycle latency); error cleared; row_idx=0.
  - start is ignored in every other state.
- S_PRELOAD: cmd held at PRELOAD until ack==PRELOAD_FIN -> S_SHIFT.
- S_SHIFT:
  - cmd=SHIFT and kernel_en=1, held until ack==SHIFT_FIN.
  - On SHIFT_FIN: row_valid pulses for 1 cycle with row_idx = the completed row.
  - If row_idx==IMAGE_ROWS-KERNEL_SIZE -> S_DONE; else row_idx+1 -> S_LOAD.
- S_LOAD: cmd=LOAD until ack==LOAD_FIN -> S_SHIFT.
- S_DONE: cmd=IDLE, done=1 for 1 cycle, busy=0 -> S_IDLE.
- S_ERR: cmd=IDLE, error=1, busy=0 -> S_IDLE on the next cycle; error stays set.
- Handshake rules:
  - cmd is level-held until its matching ack.
  - cmd drops to IDLE for exactly one cycle between commands, i.e. the cycle after the ack; the new command appears the following cycle.
  - An ack not matching the pending cmd is ignored; it does not reset the timeout.
  - The interface is never issued two commands without an intervening IDLE cycle.
- Timeout:
  - The counter resets on every cmd issue and increments each enabled cycle while waiting.
  - Reaching TIMEOUT -> S_ERR; a matching ack on that same cycle wins over the timeout.
- abort: in any non-idle state -> S_IDLE next cycle, with cmd=IDLE, kernel_en=0, busy=0, no done pulse, row_idx=0. abort beats a simultaneous ack.
- enable=0: no state change; the timeout counter does not advance; pulses (row_valid, done) are not generated; an ack arriving while enable=0 is lost. The upstream contract requires ack only when enabled.
- Arithmetic: row_idx increments by 1 and never wraps within a map. Widths are unsigned.

Decomposition:
- Shared package conv_layer_pkg:
  - cmd_t and ack_t 2-bit enums, with the encodings above, shared with the input interface.
  - Local state enum.
  - Default KERNEL_SIZE/IMAGE_ROWS constants.
- One natural sub-module, conv_layer_ack_timer: loadable timeout counter with clear/enable inputs and an expired output.

Test Plan:
- IMAGE_ROWS=8, KERNEL_SIZE=3; start; responder acks each cmd after 5 cycles -> cmd sequence PRELOAD, SHIFT, then (LOAD, SHIFT)x5 = 12 commands; 6 row_valid pulses with row_idx 0..5; one done pulse; busy low afterwards.
- Inject ack=LOAD_FIN while cmd=SHIFT -> ignored; cmd stays SHIFT; a later SHIFT_FIN advances normally.
- No ack after PRELOAD for 64 cycles -> error=1 and cmd=IDLE on cycle 65; next start clears error.
- abort during the 3rd SHIFT, same cycle as SHIFT_FIN -> no row_valid, no done; S_IDLE with row_idx=0.
- Hold enable=0 for 10 cycles mid-LOAD -> cmd and timeout frozen; resumes with an identical sequence.
- rst pulse asynchronously mid-map -> all outputs at reset values before the next clk edge.
